// File: rtl/combo_pkg.sv
// Shared definitions for the combination safe: lockout FSM states and the
// active-low seven-segment constants used by the HEX display path.
package combo_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        LOCKOUT = 2'd1,
        DRAIN   = 2'd2
    } lockout_state_t;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_O   = 7'h40;
    localparam logic [6:0] SEG_P   = 7'h0C;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_N   = 7'h2B;
    localparam logic [6:0] SEG_L   = 7'h47;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_K   = 7'h09;
    localparam logic [6:0] SEG_D   = 7'h21;

    localparam logic [27:0] HEX_OPEN   = {SEG_O, SEG_P, SEG_E, SEG_N};
    localparam logic [41:0] HEX_LOCKED = {SEG_L, SEG_O, SEG_C, SEG_K, SEG_E, SEG_D};

    function automatic logic [6:0] seg_digit(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/combo_tick_gen.sv
// One-pulse-per-TICK_CYCLES prescaler; clear holds it at zero so the first
// tick after release arrives exactly TICK_CYCLES cycles later.
module combo_tick_gen #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/combo_lockout_ctrl.sv
// Failed-attempt lockout controller between keypad front end and safe FSM.
// Define LOCKOUT_ESCALATE_EN to double the lockout length per lock_level.
module combo_lockout_ctrl
    import combo_pkg::*;
#(
    parameter int MAX_FAILS    = 3,
    parameter int LOCK_SECONDS = 10,
    parameter int TICK_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    input  logic       key_validn_sync,
    input  logic       check,
    input  logic       match,
    output logic       press_out,
    output logic       locked,
    output logic [7:0] secs_left,
    output logic [2:0] fail_cnt,
    output logic [1:0] lock_level
);

    localparam logic [2:0] MAX_F     = 3'(MAX_FAILS);
    localparam logic [7:0] LOAD_BASE = 8'(LOCK_SECONDS);

    lockout_state_t state, state_next;
    logic [7:0]     secs_next, load_value;
    logic [2:0]     fail_next, fail_inc;
    logic [1:0]     level_next;
    logic           tick;

    combo_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state != LOCKOUT),
        .tick  (tick)
    );

`ifdef LOCKOUT_ESCALATE_EN
    assign load_value = LOAD_BASE << lock_level;
`else
    assign load_value = LOAD_BASE;
`endif

    assign fail_inc = fail_cnt + 3'd1;
    assign locked   = (state != ARMED);

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        fail_next  = fail_cnt;
        level_next = lock_level;
        secs_next  = secs_left;
        press_out  = 1'b0;
        case (state)
            ARMED: begin
                press_out = press;
                if (check) begin
                    if (match) begin
                        fail_next  = '0;
                        level_next = '0;
                    end else if (fail_inc == MAX_F) begin
                        fail_next  = MAX_F;
                        secs_next  = load_value;
                        state_next = LOCKOUT;
                        press_out  = 1'b0;
                    end else begin
                        fail_next = fail_inc;
                    end
                end
            end
            LOCKOUT: begin
                if (tick) begin
                    if (secs_left <= 8'd1) begin
                        secs_next  = '0;
                        state_next = DRAIN;
                    end else begin
                        secs_next = secs_left - 8'd1;
                    end
                end
            end
            DRAIN: begin
                // Wait for key release so a key held through expiry never leaks a press.
                if (key_validn_sync) begin
                    state_next = ARMED;
                    fail_next  = '0;
                    if (lock_level != 2'd3) level_next = lock_level + 2'd1;
                end
            end
            default: state_next = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARMED;
            fail_cnt   <= '0;
            lock_level <= '0;
            secs_left  <= '0;
        end else begin
            state      <= state_next;
            fail_cnt   <= fail_next;
            lock_level <= level_next;
            secs_left  <= secs_next;
        end
    end

endmodule

// File: tb/tb_combo_lockout_ctrl.sv
// Directed bench for combo_lockout_ctrl with an expected-value scoreboard;
// expectations follow LOCKOUT_ESCALATE_EN when it is defined for the build.
module tb_combo_lockout_ctrl;

    localparam int MAX_FAILS    = 3;
    localparam int LOCK_SECONDS = 3;
    localparam int TICK_CYCLES  = 4;

    typedef struct packed {
        logic       po;
        logic       lk;
        logic [7:0] sl;
        logic [2:0] fc;
        logic [1:0] ll;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       press = 1'b0;
    logic       key_validn_sync = 1'b1;
    logic       chk = 1'b0;
    logic       mtch = 1'b0;
    logic       press_out;
    logic       locked;
    logic [7:0] secs_left;
    logic [2:0] fail_cnt;
    logic [1:0] lock_level;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_asserts = 0;
    int    n_fails   = 0;

    combo_lockout_ctrl #(
        .MAX_FAILS   (MAX_FAILS),
        .LOCK_SECONDS(LOCK_SECONDS),
        .TICK_CYCLES (TICK_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .press          (press),
        .key_validn_sync(key_validn_sync),
        .check          (chk),
        .match          (mtch),
        .press_out      (press_out),
        .locked         (locked),
        .secs_left      (secs_left),
        .fail_cnt       (fail_cnt),
        .lock_level     (lock_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int load_for(input int ll);
`ifdef LOCKOUT_ESCALATE_EN
        return LOCK_SECONDS << ll;
`else
        return LOCK_SECONDS + 0 * ll;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".press_out"},  8'(press_out),  8'(e.po));
        check({t, ".locked"},     8'(locked),     8'(e.lk));
        check({t, ".secs_left"},  secs_left,      e.sl);
        check({t, ".fail_cnt"},   8'(fail_cnt),   8'(e.fc));
        check({t, ".lock_level"}, 8'(lock_level), 8'(e.ll));
    endtask

    // Drive one cycle of inputs just after the edge; registered outputs seen
    // at the following negedge reflect the state before these inputs commit.
    task automatic step(input string tag, input logic r, input logic p, input logic kv,
                        input logic ck, input logic mt, input logic e_po, input logic e_lk,
                        input int e_sl, input int e_fc, input int e_ll);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; press = p; key_validn_sync = kv; chk = ck; mtch = mt;
        e.po = e_po; e.lk = e_lk; e.sl = 8'(e_sl); e.fc = 3'(e_fc); e.ll = 2'(e_ll);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic enter_lockout(input int ll);
        step("fail_a",    0, 0, 1, 1, 0, 0, 0, 0, 0, ll);
        step("fail_b",    0, 0, 1, 1, 0, 0, 0, 0, 1, ll);
        step("fail_trig", 0, 1, 1, 1, 0, 0, 0, 0, 2, ll);
    endtask

    task automatic run_lockout(input int ll, input int cycles, input bit hold);
        int load;
        load = load_for(ll);
        for (int k = 0; k < cycles; k++) begin
            step($sformatf("lock_l%0d_k%0d", ll, k), 0, k[0], !hold,
                 (k % 3) == 1, (k % 6) == 4, 0, 1, load - k / 4, MAX_FAILS, ll);
        end
    endtask

    initial begin
        int ll;

        step("reset",        1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("pass_press1",  0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        step("pass_idle",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("pass_press2",  0, 1, 1, 0, 0, 1, 0, 0, 0, 0);

        step("mc_fail1",     0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("mc_fail2",     0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        step("mc_match",     0, 1, 1, 1, 1, 1, 0, 0, 2, 0);
        step("mc_fail3",     0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("mc_nolock",    0, 0, 1, 1, 1, 0, 0, 0, 1, 0);

        enter_lockout(0);
        run_lockout(0, TICK_CYCLES * load_for(0), 1'b1);
        step("drain_hold0",   0, 1, 0, 0, 0, 0, 1, 0, MAX_FAILS, 0);
        step("drain_hold1",   0, 1, 0, 0, 0, 0, 1, 0, MAX_FAILS, 0);
        step("drain_release", 0, 0, 1, 0, 0, 0, 1, 0, MAX_FAILS, 0);
        step("armed_after",   0, 1, 1, 0, 0, 1, 0, 0, 0, 1);

        for (int n = 1; n <= 4; n++) begin
            ll = (n > 3) ? 3 : n;
            enter_lockout(ll);
            run_lockout(ll, TICK_CYCLES * load_for(ll), 1'b0);
            step($sformatf("drain%0d", n), 0, 0, 1, 0, 0, 0, 1, 0, MAX_FAILS, ll);
            step($sformatf("armed%0d", n), 0, 1, 1, 0, 0, 1, 0, 0, 0, (ll == 3) ? 3 : ll + 1);
        end

        enter_lockout(3);
        run_lockout(3, TICK_CYCLES * (load_for(3) - 2), 1'b0);
        step("rst_mid",        1, 1, 1, 1, 0, 0, 1, 2, MAX_FAILS, 3);
        step("post_rst",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst_press", 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
